// File: rtl/frame_stream_arbiter.sv
// frame_stream_arbiter: frame-atomic round-robin merge of N_CH framed word streams onto one tagged output stream.
// Ports:
//   i_clk, i_reset         clock, asynchronous active-high reset
//   i_s_req[N_CH]          channel has a complete frame pending
//   i_s_valid[N_CH]        per-channel word valid
//   i_s_data[N_CH*DW]      per-channel word, channel i at [i*DW +: DW]
//   o_s_ready[N_CH]        one-hot grant back to the channel generators
//   i_m_ready              downstream can absorb a whole frame (looked at only when granting)
//   o_m_valid/o_m_data     forwarded word, one register stage behind the input
//   o_m_ch_id              source channel of o_m_data
//   o_m_last               o_m_data is the footer
//   o_frame_err            one-cycle pulse on a framing error
//   o_busy                 arbiter is not idle
module frame_stream_arbiter #(
    parameter int          N_CH            = 4,
    parameter int          DATA_WIDTH      = 64,
    parameter int          FRAME_LEN_WIDTH = 10,
    parameter logic [7:0]  HEADER_ID       = 8'hAA,
    parameter logic [7:0]  FOOTER_ID       = 8'h55,
    parameter int          GRANT_TIMEOUT   = 16
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic [N_CH-1:0]              i_s_req,
    input  logic [N_CH-1:0]              i_s_valid,
    input  logic [N_CH*DATA_WIDTH-1:0]   i_s_data,
    output logic [N_CH-1:0]              o_s_ready,
    input  logic                         i_m_ready,
    output logic                         o_m_valid,
    output logic [DATA_WIDTH-1:0]        o_m_data,
    output logic [$clog2(N_CH)-1:0]      o_m_ch_id,
    output logic                         o_m_last,
    output logic                         o_frame_err,
    output logic                         o_busy
);
    localparam int CW = $clog2(N_CH);
    localparam int TW = $clog2(GRANT_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, GRANT, BODY, FOOTER, DRAIN} state_t;

    state_t                     r_state;
    logic [CW-1:0]              r_ptr;
    logic [CW-1:0]              r_sel;
    logic [TW-1:0]              r_timer;
    logic [FRAME_LEN_WIDTH-1:0] r_rem;

    logic [CW-1:0]              w_sel;
    logic                       w_vld;
    logic [DATA_WIDTH-1:0]      w_word;
    logic                       w_hdr_ok;
    logic                       w_ftr_ok;

    assign w_vld    = i_s_valid[r_sel];
    assign w_word   = i_s_data[r_sel*DATA_WIDTH +: DATA_WIDTH];
    assign w_hdr_ok = w_word[DATA_WIDTH-1 -: 8] == HEADER_ID;
    assign w_ftr_ok = w_word[7:0] == FOOTER_ID;
    assign o_busy   = r_state != IDLE;

    // Scan downward so the last hit wins: that is the first requester above the pointer.
    always_comb begin
        w_sel = '0;
        for (int i = N_CH; i >= 1; i--)
            if (i_s_req[(int'(r_ptr) + i) % N_CH]) w_sel = CW'((int'(r_ptr) + i) % N_CH);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_ptr       <= CW'(N_CH - 1);
            r_sel       <= '0;
            r_timer     <= '0;
            r_rem       <= '0;
            o_s_ready   <= '0;
            o_m_valid   <= 1'b0;
            o_m_data    <= '0;
            o_m_ch_id   <= '0;
            o_m_last    <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_m_valid   <= 1'b0;
            o_m_last    <= 1'b0;
            o_frame_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_m_ready && |i_s_req) begin
                        r_sel     <= w_sel;
                        o_s_ready <= {{(N_CH-1){1'b0}}, 1'b1} << w_sel;
                        r_timer   <= '0;
                        r_state   <= GRANT;
                    end
                end
                GRANT: begin
                    if (w_vld) begin
                        o_s_ready <= '0;
                        if (w_hdr_ok) begin
                            o_m_valid <= 1'b1;
                            o_m_data  <= w_word;
                            o_m_ch_id <= r_sel;
                            r_rem     <= w_word[FRAME_LEN_WIDTH-1:0];
                            r_state   <= (w_word[FRAME_LEN_WIDTH-1:0] == '0) ? FOOTER : BODY;
                        end else begin
                            o_frame_err <= 1'b1;
                            r_state     <= DRAIN;
                        end
                    end else if (r_timer == TW'(GRANT_TIMEOUT - 1)) begin
                        // Idle grant withdrawn; the pointer moves on so the silent channel goes last.
                        o_s_ready <= '0;
                        r_ptr     <= r_sel;
                        r_state   <= IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                BODY: begin
                    if (w_vld) begin
                        o_m_valid <= 1'b1;
                        o_m_data  <= w_word;
                        o_m_ch_id <= r_sel;
                        r_rem     <= r_rem - 1'b1;
                        if (r_rem == FRAME_LEN_WIDTH'(1)) r_state <= FOOTER;
                    end else begin
                        o_frame_err <= 1'b1;
                        r_state     <= DRAIN;
                    end
                end
                FOOTER: begin
                    if (w_vld) begin
                        o_m_valid   <= 1'b1;
                        o_m_data    <= w_word;
                        o_m_ch_id   <= r_sel;
                        o_m_last    <= 1'b1;
                        o_frame_err <= !w_ftr_ok;
                        r_ptr       <= r_sel;
                        r_state     <= IDLE;
                    end else begin
                        o_frame_err <= 1'b1;
                        r_state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Swallow the remainder of a broken frame until the generator goes quiet.
                    if (!w_vld) begin
                        r_ptr   <= r_sel;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
